norm_rr_scheduler: RTL and testbench
====================================

// Module: norm_rr_scheduler
// PURPOSE
//  Shares one leading-one normalizer between NREQ requesters. Round-robin arbitration, 2-stage valid/ready pipeline.
//  Each grant captures the winner's vector; next stage left-shifts it until MSB=1 and returns result, shift count, requester id.
//  Sits between the mantissa producers and the downstream rounding/packing logic.
// PARAMETERS
//  DATA_W   8   width of each vector / result
//  NREQ     4   number of requesters (>=1)
//  (local) SHIFT_W = $clog2(DATA_W)+1 ; ID_W = (NREQ>1) ? $clog2(NREQ) : 1
// PORTS
//  clk        in   1              single clock, rising edge
//  rst        in   1              synchronous, active-high reset
//  req_valid  in   NREQ           requester i has a vector
//  req_data   in   NREQ*DATA_W    requester i vector at [i*DATA_W +: DATA_W]
//  req_ready  out  NREQ           one-hot grant; transfer when req_valid[i]&req_ready[i]
//  out_valid  out  1              result available
//  out_ready  in   1              downstream accepts result
//  out_data   out  DATA_W         normalized vector (vector << shift)
//  out_shift  out  SHIFT_W        leading-zero count; DATA_W when vector==0
//  out_zero   out  1              input vector was all zeros
//  out_id     out  ID_W           index of requester that supplied it
// BEHAVIOUR
//  Reset: out_valid=0, out_data/out_shift/out_id/out_zero=0, s1_valid=0, rr pointer=0, req_ready=0 while rst=1.
//  Stage S1 (capture): s1 regs {valid,data,id}. S1 loads when (!s1_valid || s1_advance).
//   s1_advance = s1_valid && (!out_valid || out_ready).
//  Arbitration: combinational; only when S1 can load. Search order ptr, ptr+1, ... NREQ-1, 0, ... ptr-1 (mod NREQ).
//   req_ready = one-hot of first valid requester in that order; all-zero when S1 cannot load or no request.
//   On grant to i: ptr <= (i+1) mod NREQ. No grant -> ptr unchanged. req_ready never depends on out_ready path
//   beyond the S1 load condition above (no comb path req_valid->req_ready of other requesters except via arbiter).
//  Stage S2 (normalize): on s1_advance, out regs load: shift = count of leading zeros of s1_data (MSB first),
//   out_data = s1_data << shift, out_zero = (s1_data==0), out_id = s1_id, out_valid <= 1.
//   Else if out_ready: out_valid <= 0. Zero vector: shift=DATA_W, out_data=0, out_zero=1.
//  Latency: grant cycle edge -> S1; next edge -> out regs. out_valid rises 2 cycles after req handshake.
//  Throughput: 1 result/cycle with out_ready=1; both stages fill and hold under backpressure (max 2 in flight).
//  Stability: while out_valid && !out_ready, out_* hold unchanged; S1 holds; req_ready all 0.
//  Simultaneous: output drained and S1 refilled in same cycle when out_ready=1 (no bubble).
//  Width rules: shift fits SHIFT_W unsigned; data shift is logical, zero-fill from LSB; no truncation of leading one.
//  Reset mid-operation: in-flight S1/S2 contents discarded, no result emitted for them, ptr back to 0.
//  NREQ=1: arbiter degenerates to req_ready[0] = S1 can load; out_id=0.
// STRUCTURE
//  Package norm_pkg: SHIFT_W/ID_W derivation functions, lzc function (leading-zero count, returns DATA_W on zero).
//  Sub-module rr_arbiter (#NREQ): inputs req, en, ptr; outputs one-hot grant and encoded index.
//  Top: arbiter + S1 regs + LZC/shift combinational + S2 regs + ptr reg. Single always block per stage.
// TESTING  (DATA_W=8, NREQ=4)
//  1. req_valid=0001, data0=8'b0001_0110, out_ready=1 -> 2 cycles later out_data=8'b1011_0000, shift=3, id=0, zero=0.
//  2. data2=8'h00 alone -> out_data=0, shift=8, zero=1, id=2; data1=8'h80 -> shift=0, out_data=8'h80.
//  3. req_valid=1111 held, out_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; out_id same order, no gaps.
//  4. req_valid=1111, out_ready=0 for 6 cycles -> exactly 2 grants (ids 0,1), out_* stable, req_ready=0 after;
//     out_ready=1 -> ids 0,1 delivered, then 2,3 granted next.
//  5. Grant to 3, then only req 1 valid -> ptr wraps to 0, grant 1; check ptr=2 afterwards via next order.
//  6. rst=1 with 2 results in flight -> next cycle out_valid=0, req_ready=0; after release first grant goes to req 0.

Source files
------------

// File: rtl/norm_rr_scheduler_pkg.sv
// Shared helpers for the normalizer scheduler: local width derivation and
// the leading-zero count used by the normalize stage.
package norm_pkg;

  localparam int MAX_DATA_W = 64;

  function automatic int calcShiftW(input int dataW);
    return $clog2(dataW) + 1;
  endfunction

  function automatic int calcIdW(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Counts zeros from bit width-1 downward; an all-zero vector yields width.
  function automatic int lzc(input logic [MAX_DATA_W-1:0] vec, input int width);
    int count;
    logic found;
    count = width;
    found = 1'b0;
    for (int b = MAX_DATA_W - 1; b >= 0; b--) begin
      if (b < width && !found && vec[b]) begin
        count = width - 1 - b;
        found = 1'b1;
      end
    end
    return count;
  endfunction

endpackage

// File: rtl/norm_rr_scheduler_arbiter.sv
// Round-robin arbiter: first asserted request at or after the pointer wins,
// otherwise the lowest asserted request below the pointer.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  input  logic [ID_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [ID_W-1:0] o_idx,
  output logic            o_valid
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    if (i_en) begin
      for (int c = 0; c < NREQ; c++) begin
        if (!o_valid && c >= int'(i_ptr) && i_req[c]) begin
          o_valid    = 1'b1;
          o_grant[c] = 1'b1;
          o_idx      = ID_W'(c);
        end
      end
      for (int c = 0; c < NREQ; c++) begin
        if (!o_valid && c < int'(i_ptr) && i_req[c]) begin
          o_valid    = 1'b1;
          o_grant[c] = 1'b1;
          o_idx      = ID_W'(c);
        end
      end
    end
  end

endmodule

// File: rtl/norm_rr_scheduler.sv
// One leading-one normalizer shared by NREQ requesters: round-robin grant into
// a capture stage, then a normalize stage holding the result for downstream.
module norm_rr_scheduler
  import norm_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NREQ    = 4,
  localparam int SHIFT_W = calcShiftW(DATA_W),
  localparam int ID_W    = calcIdW(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SHIFT_W-1:0]     out_shift,
  output logic                   out_zero,
  output logic [ID_W-1:0]        out_id
);

  logic                 r_s1Valid;
  logic [DATA_W-1:0]    r_s1Data;
  logic [ID_W-1:0]      r_s1Id;
  logic [ID_W-1:0]      r_ptr;
  logic                 r_outValid;
  logic [DATA_W-1:0]    r_outData;
  logic [SHIFT_W-1:0]   r_outShift;
  logic                 r_outZero;
  logic [ID_W-1:0]      r_outId;

  logic                 w_s1Advance;
  logic                 w_s1Load;
  logic                 w_arbEn;
  logic [NREQ-1:0]      w_grant;
  logic [ID_W-1:0]      w_gntIdx;
  logic                 w_gntValid;
  logic [ID_W-1:0]      w_ptrNext;
  logic [DATA_W-1:0]    w_selData;
  logic [SHIFT_W-1:0]   w_lzc;
  logic [DATA_W-1:0]    w_normData;

  assign w_s1Advance = r_s1Valid && (!r_outValid || out_ready);
  assign w_s1Load    = !r_s1Valid || w_s1Advance;
  // Reset gates the arbiter so no handshake can complete while rst is held.
  assign w_arbEn     = w_s1Load && !rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arbiter (
    .i_req   (req_valid),
    .i_en    (w_arbEn),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gntIdx),
    .o_valid (w_gntValid)
  );

  assign req_ready = w_grant;
  assign w_ptrNext = (w_gntIdx == ID_W'(NREQ - 1)) ? '0 : w_gntIdx + ID_W'(1);

  always_comb begin
    w_selData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_selData = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Shifting by DATA_W for a zero vector naturally yields an all-zero result.
  assign w_lzc      = SHIFT_W'(lzc(MAX_DATA_W'(r_s1Data), DATA_W));
  assign w_normData = r_s1Data << w_lzc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Data  <= '0;
      r_s1Id    <= '0;
      r_ptr     <= '0;
    end else if (w_s1Load) begin
      r_s1Valid <= w_gntValid;
      r_s1Data  <= w_selData;
      r_s1Id    <= w_gntIdx;
      if (w_gntValid) r_ptr <= w_ptrNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outShift <= '0;
      r_outZero  <= 1'b0;
      r_outId    <= '0;
    end else if (w_s1Advance) begin
      r_outValid <= 1'b1;
      r_outData  <= w_normData;
      r_outShift <= w_lzc;
      r_outZero  <= (r_s1Data == '0);
      r_outId    <= r_s1Id;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_shift = r_outShift;
  assign out_zero  = r_outZero;
  assign out_id    = r_outId;

endmodule

// File: tb/tb_norm_rr_scheduler.sv
// Directed bench for norm_rr_scheduler with a slot-level reference model
// compared every cycle, plus literal expectations from hand-worked scenarios.
module tb_norm_rr_scheduler;

  localparam int DATA_W  = 8;
  localparam int NREQ    = 4;
  localparam int SHIFT_W = 4;
  localparam int ID_W    = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ*DATA_W-1:0] req_data = '0;
  logic                   out_ready = 1'b1;
  logic [NREQ-1:0]        req_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [SHIFT_W-1:0]     out_shift;
  logic                   out_zero;
  logic [ID_W-1:0]        out_id;

  int testsRun = 0;
  int testsFailed = 0;
  int grantLog[$];
  int outLog[$];

  norm_rr_scheduler #(.DATA_W(DATA_W), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shift (out_shift),
    .out_zero  (out_zero),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rstIn, input logic [NREQ-1:0] valid, input logic outRdy);
    @(posedge clk);
    #1;
    rst       = rstIn;
    req_valid = valid;
    out_ready = outRdy;
  endtask

  task automatic setData(input int idx, input logic [DATA_W-1:0] val);
    for (int i = 0; i < NREQ; i++) begin
      if (i == idx) req_data[i*DATA_W +: DATA_W] = val;
    end
  endtask

  task automatic waitOut(input string name, input logic [7:0] expData, input int expShift,
                         input logic expZero, input int expId);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkOutput({name, " seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({name, " data"}, 32'(out_data), 32'(expData));
      checkOutput({name, " shift"}, 32'(out_shift), 32'(expShift));
      checkOutput({name, " zero"}, 32'(out_zero), 32'(expZero));
      checkOutput({name, " id"}, 32'(out_id), 32'(expId));
    end
  endtask

  task automatic checkSeq(input string name, input int exp[$], input int got[$]);
    checkOutput({name, " len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      checkOutput($sformatf("%s[%0d]", name, i), (i < got.size()) ? 32'(got[i]) : 32'hffffffff, 32'(exp[i]));
    end
  endtask

  function automatic void normRef(input logic [7:0] d, output logic [7:0] nd, output int sh);
    nd = d;
    sh = 0;
    if (d == 8'h00) sh = DATA_W;
    else while (!nd[DATA_W-1]) begin
      nd = nd << 1;
      sh++;
    end
  endfunction

  // Reference: an output slot and a capture slot; data advances when there is room.
  logic             mS1Valid = 1'b0;
  logic [7:0]       mS1Data = '0;
  int               mS1Id = 0;
  logic             mOutValid = 1'b0;
  logic [7:0]       mOutData = '0;
  int               mOutShift = 0;
  logic             mOutZero = 1'b0;
  int               mOutId = 0;
  int               mPtr = 0;
  int               winner;
  int               cand;
  logic             moves;
  logic             canLoad;
  logic [NREQ-1:0]  expGrant;
  logic [7:0]       nd;
  int               ns;
  logic [7:0]       capData;

  always @(negedge clk) begin
    moves   = mS1Valid && (!mOutValid || out_ready);
    canLoad = !mS1Valid || moves;
    winner  = -1;
    if (!rst && canLoad) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = (mPtr + k) % NREQ;
        if (winner < 0 && req_valid[cand]) winner = cand;
      end
    end
    expGrant = '0;
    capData  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (i == winner) begin
        expGrant[i] = 1'b1;
        capData     = req_data[i*DATA_W +: DATA_W];
      end
    end

    checkOutput("req_ready", 32'(req_ready), 32'(expGrant));
    checkOutput("out_valid", 32'(out_valid), 32'(mOutValid));
    checkOutput("out_data", 32'(out_data), 32'(mOutData));
    checkOutput("out_shift", 32'(out_shift), 32'(mOutShift));
    checkOutput("out_zero", 32'(out_zero), 32'(mOutZero));
    checkOutput("out_id", 32'(out_id), 32'(mOutId));

    for (int i = 0; i < NREQ; i++) if (req_ready[i]) grantLog.push_back(i);
    if (out_valid && out_ready) outLog.push_back(int'(out_id));

    if (rst) begin
      mS1Valid = 1'b0; mS1Data = '0; mS1Id = 0; mPtr = 0;
      mOutValid = 1'b0; mOutData = '0; mOutShift = 0; mOutZero = 1'b0; mOutId = 0;
    end else begin
      if (moves) begin
        normRef(mS1Data, nd, ns);
        mOutValid = 1'b1; mOutData = nd; mOutShift = ns;
        mOutZero = (mS1Data == 8'h00); mOutId = mS1Id;
      end else if (out_ready) begin
        mOutValid = 1'b0;
      end
      if (canLoad) begin
        mS1Valid = (winner >= 0);
        if (winner >= 0) begin
          mS1Data = capData;
          mS1Id   = winner;
          mPtr    = (winner + 1) % NREQ;
        end
      end
    end
  end

  initial begin
    int e[$];

    applyStimulus(1'b1, 4'b0000, 1'b1);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    @(negedge clk); #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);

    // Single requests: basic normalize, all-zero vector, MSB already set.
    setData(0, 8'b0001_0110);
    applyStimulus(1'b0, 4'b0001, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    waitOut("t1", 8'b1011_0000, 3, 1'b0, 0);

    setData(2, 8'h00);
    applyStimulus(1'b0, 4'b0100, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    waitOut("t2 zero", 8'h00, 8, 1'b1, 2);

    setData(1, 8'h80);
    applyStimulus(1'b0, 4'b0010, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    waitOut("t2 msb", 8'h80, 0, 1'b0, 1);

    // Pointer is at 2; a lone grant to 3 wraps it back to 0.
    applyStimulus(1'b0, 4'b1000, 1'b1);
    repeat (4) applyStimulus(1'b0, 4'b0000, 1'b1);

    setData(0, 8'h01); setData(1, 8'h3C); setData(2, 8'h7F); setData(3, 8'h00);
    grantLog.delete(); outLog.delete();
    repeat (6) applyStimulus(1'b0, 4'b1111, 1'b1);
    repeat (5) applyStimulus(1'b0, 4'b0000, 1'b1);
    e = '{0, 1, 2, 3, 0, 1};
    checkSeq("t3 grants", e, grantLog);
    checkSeq("t3 ids", e, outLog);

    applyStimulus(1'b0, 4'b1000, 1'b1);
    repeat (4) applyStimulus(1'b0, 4'b0000, 1'b1);

    // Backpressure: both stages fill, then nothing more is granted.
    grantLog.delete(); outLog.delete();
    repeat (6) applyStimulus(1'b0, 4'b1111, 1'b0);
    @(negedge clk); #1;
    checkOutput("t4 held valid", 32'(out_valid), 32'd1);
    checkOutput("t4 held id", 32'(out_id), 32'd0);
    checkOutput("t4 held data", 32'(out_data), 32'h80);
    checkOutput("t4 ready low", 32'(req_ready), 32'd0);
    e = '{0, 1};
    checkSeq("t4 stalled grants", e, grantLog);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    repeat (5) applyStimulus(1'b0, 4'b0000, 1'b1);
    e = '{0, 1, 2, 3};
    checkSeq("t4 grants", e, grantLog);
    checkSeq("t4 ids", e, outLog);

    grantLog.delete(); outLog.delete();
    applyStimulus(1'b0, 4'b1000, 1'b1);
    applyStimulus(1'b0, 4'b0010, 1'b1);
    applyStimulus(1'b0, 4'b1011, 1'b1);
    repeat (5) applyStimulus(1'b0, 4'b0000, 1'b1);
    e = '{3, 1, 3};
    checkSeq("t5 grants", e, grantLog);

    // Reset with two results in flight discards both and rewinds the pointer.
    grantLog.delete(); outLog.delete();
    applyStimulus(1'b0, 4'b0110, 1'b0);
    applyStimulus(1'b0, 4'b0110, 1'b0);
    applyStimulus(1'b1, 4'b0110, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    @(negedge clk); #1;
    checkOutput("t6 rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6 rst req_ready", 32'(req_ready), 32'd0);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    @(negedge clk); #1;
    checkOutput("t6 first grant", 32'(req_ready), 32'b0001);
    repeat (5) applyStimulus(1'b0, 4'b0000, 1'b1);
    e = '{1, 2, 0};
    checkSeq("t6 grants", e, grantLog);
    e = '{0};
    checkSeq("t6 ids", e, outLog);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
